// File: rtl/stack_frame_ctrl.sv
// stack_frame_ctrl
// Call-frame manager that sits between a user and a SuperStack. It owns the
// SuperStack underflow limit (the base of the current frame) and a LIFO of
// the limits saved by each CALL, so nested frames can be entered and left.
//
// Op encoding on usr_op / stack_op:
//   0 NONE, 1 PUSH, 2 POP, 6 UNDERFLOW_RESET, 7 UNDERFLOW_RESET_PUSH
// Status encoding on stack_status: 0 NONE, 1 OVERFLOW, 2 UNDERFLOW
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   cmd_valid / cmd_ready  frame command handshake
//   cmd, cmd_count         0 = CALL (count = arguments), 1 = RETURN (bit0 = one result)
//   done, error            one-cycle completion / rejection pulses
//   err_code               1 overflow, 2 no frame, 3 too few operands (held)
//   frame_depth            current nesting level
//   usr_op/data/offset     user stack request, forwarded only in IDLE
//   stack_op/data/offset   request to the SuperStack
//   stack_underflow_limit  current frame base
//   stack_index/out/status SuperStack feedback
//   state_dbg              current FSM state
//
// Handshake: a command is accepted on the rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, so a held
// cmd_valid is taken again only once the previous command has finished.
module stack_frame_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int FRAMES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd,
    input  logic [DEPTH:0]               cmd_count,
    output logic                         done,
    output logic                         error,
    output logic [1:0]                   err_code,
    output logic [$clog2(FRAMES+1)-1:0]  frame_depth,
    input  logic [2:0]                   usr_op,
    input  logic [WIDTH-1:0]             usr_data,
    input  logic [DEPTH:0]               usr_offset,
    output logic [2:0]                   stack_op,
    output logic [WIDTH-1:0]             stack_data,
    output logic [DEPTH:0]               stack_offset,
    output logic [DEPTH:0]               stack_underflow_limit,
    input  logic [DEPTH:0]               stack_index,
    input  logic [WIDTH-1:0]             stack_out,
    input  logic [2:0]                   stack_status,
    output logic [2:0]                   state_dbg
);
    localparam int FW = $clog2(FRAMES + 1);
    localparam int IW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_UR      = 3'd6;
    localparam logic [2:0] OP_UR_PUSH = 3'd7;
    localparam logic [2:0] ST_OVERFLOW = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ERR         = 3'd1,
        S_CALL_SETTLE = 3'd2,
        S_RET_DROP    = 3'd3,
        S_RET_SETTLE  = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH:0]     limit_q, limit_d;
    logic [DEPTH:0]     lifo_q [FRAMES];
    logic [DEPTH:0]     lifo_d [FRAMES];
    logic [FW-1:0]      depth_q, depth_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               one_q, one_d;
    logic [1:0]         err_code_q, err_code_d;

    logic [DEPTH:0]     avail;
    logic [FW-1:0]      depth_m1;
    logic [IW-1:0]      push_idx;
    logic [IW-1:0]      pop_idx;

    // Operands belonging to the current frame.
    assign avail    = stack_index - limit_q;
    assign depth_m1 = depth_q - FW'(1);
    assign push_idx = depth_q[IW-1:0];
    assign pop_idx  = depth_m1[IW-1:0];

    assign stack_underflow_limit = limit_q;
    assign frame_depth           = depth_q;
    assign err_code              = err_code_q;
    assign state_dbg             = state_q;

    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        lifo_d       = lifo_q;
        depth_d      = depth_q;
        result_d     = result_q;
        one_d        = one_q;
        err_code_d   = err_code_q;
        cmd_ready    = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        stack_op     = OP_NONE;
        stack_data   = '0;
        stack_offset = '0;

        case (state_q)
            S_IDLE: begin
                cmd_ready    = 1'b1;
                stack_op     = usr_op;
                stack_data   = usr_data;
                stack_offset = usr_offset;
                if (cmd_valid) begin
                    if (!cmd) begin
                        if (depth_q == FW'(FRAMES)) begin
                            err_code_d = 2'd1;
                            state_d    = S_ERR;
                        end else if (cmd_count > avail) begin
                            err_code_d = 2'd3;
                            state_d    = S_ERR;
                        end else begin
                            // Arguments already on the stack become the
                            // bottom of the callee's frame.
                            lifo_d[push_idx] = limit_q;
                            limit_d          = stack_index - cmd_count;
                            depth_d          = depth_q + FW'(1);
                            err_code_d       = 2'd0;
                            state_d          = S_CALL_SETTLE;
                        end
                    end else begin
                        if (depth_q == '0) begin
                            err_code_d = 2'd2;
                            state_d    = S_ERR;
                        end else if (cmd_count[0] && avail == '0) begin
                            err_code_d = 2'd3;
                            state_d    = S_ERR;
                        end else begin
                            result_d   = stack_out;
                            one_d      = cmd_count[0];
                            err_code_d = 2'd0;
                            state_d    = S_RET_DROP;
                        end
                    end
                end
            end
            S_ERR: begin
                error   = 1'b1;
                state_d = S_IDLE;
            end
            S_CALL_SETTLE: begin
                state_d = S_DONE;
            end
            S_RET_DROP: begin
                // Discard the callee frame (still using the callee limit),
                // optionally re-pushing the saved result.
                stack_op   = one_q ? OP_UR_PUSH : OP_UR;
                stack_data = result_q;
                limit_d    = lifo_q[pop_idx];
                depth_d    = depth_m1;
                state_d    = S_RET_SETTLE;
            end
            S_RET_SETTLE: begin
                // Frame state stays unwound even if the re-push overflowed.
                if (stack_status == ST_OVERFLOW) begin
                    err_code_d = 2'd1;
                    state_d    = S_ERR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            limit_q    <= '0;
            depth_q    <= '0;
            result_q   <= '0;
            one_q      <= 1'b0;
            err_code_q <= 2'd0;
            for (int i = 0; i < FRAMES; i++) begin
                lifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            depth_q    <= depth_d;
            result_q   <= result_d;
            one_q      <= one_d;
            err_code_q <= err_code_d;
            for (int i = 0; i < FRAMES; i++) begin
                lifo_q[i] <= lifo_d[i];
            end
        end
    end
endmodule
